// File: rtl/bcd_pkg.sv
// Shared types and sizes for the keypad BCD encoder and its one-hot helper.
package bcd_pkg;

    localparam int BCD_W = 4;
    localparam int KEY_N = 10;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_HOLD     = 2'd2,
        ST_RELEASE  = 2'd3
    } state_e;

endpackage

// File: rtl/onehot10_bcd.sv
// Combinational 10-line to 8421 BCD conversion with a strict one-hot flag.
module onehot10_bcd
    import bcd_pkg::*;
(
    input  logic [KEY_N-1:0] bits,
    output logic [BCD_W-1:0] bcd,
    output logic             onehot
);

    // Each BCD bit is the OR of the key lines whose index has that bit set;
    // the result is only meaningful when onehot is high.
    for (genvar gi = 0; gi < BCD_W; gi++) begin : g_bcd_bit
        logic [KEY_N-1:0] mask;
        always_comb begin
            mask = '0;
            for (int k = 0; k < KEY_N; k++) begin
                mask[k] = ((k >> gi) & 1) == 1;
            end
        end
        assign bcd[gi] = |(bits & mask);
    end

    assign onehot = (bits != '0) && ((bits & (bits - KEY_N'(1))) == '0);

endmodule

// File: rtl/encoder_10b_8421.sv
// Keypad encoder: synchronise and debounce ten key lines, deliver one BCD digit
// per clean press over valid/ready, pulse err on a stable multi-key press.
module encoder_10b_8421
    import bcd_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [KEY_N-1:0] keys,
    input  logic             ready,
    output logic [BCD_W-1:0] out,
    output logic             valid,
    output logic             err
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [KEY_N-1:0] sync1_q, ks_q;
    logic [KEY_N-1:0] snap_q, snap_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    state_e           state_q, state_d;
    logic [BCD_W-1:0] out_q, out_d;
    logic             valid_q, valid_d;
    logic             err_pend_q, err_pend_d;
    logic             err_q, err_d;

    logic [BCD_W-1:0] snap_bcd;
    logic             snap_onehot;

    onehot10_bcd u_onehot (
        .bits   (snap_q),
        .bcd    (snap_bcd),
        .onehot (snap_onehot)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q    <= '0;
            ks_q       <= '0;
            snap_q     <= '0;
            cnt_q      <= '0;
            state_q    <= ST_IDLE;
            out_q      <= '0;
            valid_q    <= 1'b0;
            err_pend_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            sync1_q    <= keys;
            ks_q       <= sync1_q;
            snap_q     <= snap_d;
            cnt_q      <= cnt_d;
            state_q    <= state_d;
            out_q      <= out_d;
            valid_q    <= valid_d;
            err_pend_q <= err_pend_d;
            err_q      <= err_d;
        end
    end

    // valid and err are registered one cycle behind the FSM decision.
    always_comb begin
        state_d    = state_q;
        snap_d     = snap_q;
        cnt_d      = cnt_q;
        out_d      = out_q;
        valid_d    = 1'b0;
        err_pend_d = 1'b0;
        err_d      = err_pend_q;
        case (state_q)
            ST_IDLE: begin
                if (ks_q != '0) begin
                    snap_d  = ks_q;
                    cnt_d   = '0;
                    state_d = ST_DEBOUNCE;
                end
            end
            ST_DEBOUNCE: begin
                if (ks_q == snap_q) begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d = '0;
                        if (snap_onehot) begin
                            out_d   = snap_bcd;
                            state_d = ST_HOLD;
                        end else begin
                            err_pend_d = 1'b1;
                            state_d    = ST_RELEASE;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else if (ks_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    snap_d = ks_q;
                    cnt_d  = '0;
                end
            end
            ST_HOLD: begin
                if (valid_q && ready) begin
                    cnt_d   = '0;
                    state_d = ST_RELEASE;
                end else begin
                    valid_d = 1'b1;
                end
            end
            ST_RELEASE: begin
                if (ks_q != '0) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign out   = out_q;
    assign valid = valid_q;
    assign err   = err_q;

endmodule

// File: tb/tb_encoder_10b_8421.sv
// Randomised scoreboard bench for the keypad BCD encoder.
module tb_encoder_10b_8421;
    import bcd_pkg::*;

    localparam int N = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] keys;
    logic       ready;
    logic [3:0] out;
    logic       valid;
    logic       err;

    encoder_10b_8421 #(.DEBOUNCE_CYCLES(N)) dut (
        .clk   (clk),
        .rst   (rst),
        .keys  (keys),
        .ready (ready),
        .out   (out),
        .valid (valid),
        .err   (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit         is_err;
        logic [3:0] val;
        int         at;
        int         len;
    } exp_t;

    exp_t       sb[$];
    int         n_checks = 0;
    int         n_fail = 0;
    logic [3:0] last_digit = 4'd0;
    int         last_chg = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, req);
        end
    endtask

    function automatic logic [9:0] rand_keys();
        logic [9:0] one = 10'd1;
        if ($urandom_range(0, 3) != 0) return one << $urandom_range(0, 9);
        return 10'($urandom_range(1, 1023));
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_for(input logic [9:0] v, input int n);
        if (v !== keys) last_chg = cyc;
        keys = v;
        repeat (n) step();
    endtask

    // Reference: a value stable from the last change yields its outcome N+4
    // cycles later; one-hot gives digit log2(v), anything else gives err.
    task automatic press_final(input logic [9:0] v, input int d, input int extra, input bit alt);
        int   exp_at;
        exp_t e;
        if (v == keys) set_for(10'd0, 1);
        set_for(v, 0);
        exp_at = last_chg + N + 4;
        ready = (d == 0);
        if ($countones(v) == 1) begin
            last_digit = 4'($clog2(v));
            e = '{is_err: 1'b0, val: last_digit, at: exp_at, len: d + 1};
        end else begin
            e = '{is_err: 1'b1, val: last_digit, at: exp_at, len: 1};
        end
        sb.push_back(e);
        while (cyc < exp_at + d + 2 + extra) begin
            if (d > 0 && cyc == exp_at + d) ready = 1'b1;
            if (alt && cyc == exp_at + 3) keys = 10'd0;
            if (alt && cyc == exp_at + 8) keys = 10'b0000000100;
            step();
        end
        ready = 1'($urandom);
        set_for(10'd0, N + 8);
    endtask

    task automatic glitches(input int ng);
        logic [9:0] v;
        for (int i = 0; i < ng; i++) begin
            do v = rand_keys(); while (v == keys);
            set_for(v, $urandom_range(1, N - 2));
            set_for(10'd0, $urandom_range(0, 3));
        end
    endtask

    // Monitor: pop an expectation whenever the DUT presents valid or err.
    initial begin : monitor
        bit   in_valid = 0;
        bit   err_prev = 0;
        int   vcount = 0;
        exp_t cur;
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                in_valid = 0;
                err_prev = 0;
            end else begin
                if (err) chk("err_width", 32'(err_prev), 0);
                if ((err && !err_prev) || (valid && !in_valid)) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_output", 32'(sb.size()), 1);
                    end else begin
                        e = sb.pop_front();
                        chk("kind_err", 32'(err), 32'(e.is_err));
                        chk("kind_valid", 32'(valid), 32'(!e.is_err));
                        chk("out", 32'(out), 32'(e.val));
                        chk("latency", cyc, e.at);
                        if (valid) begin
                            in_valid = 1;
                            cur = e;
                            vcount = 0;
                        end
                    end
                end
                if (in_valid) begin
                    if (valid) begin
                        vcount++;
                        chk("out_hold", 32'(out), 32'(cur.val));
                    end else begin
                        chk("valid_len", vcount, cur.len);
                        in_valid = 0;
                    end
                end
                if (sb.size() > 0 && cyc > sb[0].at + 4) begin
                    chk("missing_output", cyc, sb[0].at);
                    void'(sb.pop_front());
                end
                err_prev = err;
            end
        end
    end

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        int exp_at;
        rst   = 1'b1;
        keys  = 10'd0;
        ready = 1'b0;
        #1;
        chk("reset_valid", 32'(valid), 0);
        chk("reset_err", 32'(err), 0);
        chk("reset_out", 32'(out), 0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        step();

        // Clean presses, key 5 then key 9.
        press_final(10'b0000100000, 0, 20, 0);
        press_final(10'b1000000000, 0, 5, 0);

        // Bounce on key 3, then held.
        for (int i = 0; i < 4; i++) begin
            set_for(10'b0000001000, 5);
            set_for(10'd0, 5);
        end
        press_final(10'b0000001000, 0, 5, 0);

        // Two keys together.
        press_final(10'b0000000011, 0, 10, 0);

        // Back-pressure on key 7 with key 2 pressed while waiting, then key 2.
        press_final(10'b0010000000, 30, 4, 1);
        press_final(10'b0000000100, 0, 4, 0);

        // Key 0 held for a long time.
        press_final(10'b0000000001, 0, 180, 0);

        // Reset while holding a digit, key stays down.
        keys = 10'b0000010000;
        last_chg = cyc;
        ready = 1'b0;
        exp_at = last_chg + N + 4;
        last_digit = 4'd4;
        sb.push_back('{is_err: 1'b0, val: 4'd4, at: exp_at, len: 1});
        while (cyc < exp_at + 5) step();
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_valid", 32'(valid), 0);
        chk("async_rst_out", 32'(out), 0);
        chk("async_rst_err", 32'(err), 0);
        last_digit = 4'd0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        last_chg = cyc;
        exp_at = last_chg + N + 4;
        last_digit = 4'd4;
        ready = 1'b1;
        sb.push_back('{is_err: 1'b0, val: 4'd4, at: exp_at, len: 1});
        while (cyc < exp_at + 3) step();
        set_for(10'd0, N + 8);

        // Randomised traffic.
        for (int t = 0; t < 30; t++) begin
            glitches($urandom_range(0, 3));
            press_final(rand_keys(), $urandom_range(0, 8), $urandom_range(0, 10), 0);
        end

        repeat (N + 10) step();
        chk("scoreboard_empty", 32'(sb.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
